// File: rtl/synth_pkg.sv
// synth_pkg: voice parameter RAM layout, sizing and allocator FSM states
package synth_pkg;
  localparam int NUM_VOICES = 256;
  localparam int VOICE_W = 8;
  localparam int PHASE_W = 32;
  localparam int FS_HZ = 48000;
  localparam int PARAM_W = 51;
  localparam int PHASE_LSB = 0;
  localparam int WAVE_LSB = 32;
  localparam int VEL_LSB = 36;
  localparam int NOTE_LSB = 43;
  localparam int ACTIVE_BIT = 50;
  typedef enum logic [1:0] {CLEAR, IDLE, SCAN, WRITE} state_t;
  function automatic logic [PARAM_W-1:0] pack_param(input logic [6:0] note, input logic [6:0] vel,
                                                    input logic [3:0] wave, input logic [PHASE_W-1:0] phase);
    pack_param = '0;
    pack_param[ACTIVE_BIT] = 1'b1;
    pack_param[NOTE_LSB +: 7] = note;
    pack_param[VEL_LSB +: 7] = vel;
    pack_param[WAVE_LSB +: 4] = wave;
    pack_param[PHASE_LSB +: PHASE_W] = phase;
  endfunction
endpackage

// File: rtl/note_phase_rom.sv
// note_phase_rom: 128-entry registered MIDI note -> DDS delta_phase ROM built at elaboration
module note_phase_rom
  import synth_pkg::*;
(
  input  logic               clk,
  input  logic               en,
  input  logic [6:0]         addr,
  output logic [PHASE_W-1:0] phase
);
  function automatic logic [639:0] pow12(input logic [639:0] x);
    logic [639:0] x2, x4;
    x2 = x * x;
    x4 = x2 * x2;
    return x4 * x4 * x4;
  endfunction
  // Exact rounding: z = floor(2*delta) is the largest z with (z*FS)^12 <= (880*2^(PHASE_W-6+oct))^12 * 2^semi
  function automatic logic [PHASE_W-1:0] phase_of(input int n);
    logic [639:0] lim, z, t;
    lim = pow12(640'(880) << (PHASE_W - 6 + (n + 3) / 12)) << ((n + 3) % 12);
    z = '0;
    for (int i = PHASE_W; i >= 0; i--) begin
      t = z | (640'(1) << i);
      if (pow12(t * 640'(FS_HZ)) <= lim) z = t;
    end
    return PHASE_W'((z + 640'(1)) >> 1);
  endfunction
  logic [PHASE_W-1:0] rom [128];
  for (genvar g = 0; g < 128; g++) begin : g_rom
    localparam logic [PHASE_W-1:0] V = phase_of(g);
    assign rom[g] = V;
  end
  always_ff @(posedge clk) if (en) phase <= rom[addr];
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: MIDI note events -> voice parameter RAM writes; `define VOICE_STEAL_EN to steal round-robin when full
module voice_allocator
  import synth_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic               note_on,
  input  logic [6:0]         note_num,
  input  logic [6:0]         velocity,
  input  logic [3:0]         wave_sel,
  output logic               ram_we,
  output logic [VOICE_W-1:0] ram_addr,
  output logic [PARAM_W-1:0] ram_wdata,
  output logic [VOICE_W:0]   active_count,
  output logic               voice_dropped
);
  state_t state;
  logic [VOICE_W-1:0] idx;
  logic ev_on;
  logic [6:0] ev_note, ev_vel;
  logic [3:0] ev_wave;
  logic [NUM_VOICES-1:0] shadow_active;
  logic [NUM_VOICES-1:0][6:0] shadow_note;
  logic [PHASE_W-1:0] rom_phase;
  logic accept, hit, last;
`ifdef VOICE_STEAL_EN
  logic [VOICE_W-1:0] steal_ptr;
`endif
  assign accept = state == IDLE && note_ready && note_valid;
  assign hit = ev_on ? !shadow_active[idx] : shadow_active[idx] && shadow_note[idx] == ev_note;
  assign last = idx == VOICE_W'(NUM_VOICES - 1);
  note_phase_rom u_rom (.clk(clk), .en(accept), .addr(note_num), .phase(rom_phase));
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLEAR;
      idx <= '0;
      ev_on <= 1'b0;
      ev_note <= '0;
      ev_vel <= '0;
      ev_wave <= '0;
      shadow_active <= '0;
      shadow_note <= '0;
      note_ready <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      active_count <= '0;
      voice_dropped <= 1'b0;
`ifdef VOICE_STEAL_EN
      steal_ptr <= '0;
`endif
    end else begin
      ram_we <= 1'b0;
      voice_dropped <= 1'b0;
      case (state)
        CLEAR: begin
          ram_we <= 1'b1;
          ram_addr <= idx;
          ram_wdata <= '0;
          idx <= idx + 1'b1;
          if (last) state <= IDLE;
        end
        IDLE: begin
          note_ready <= !accept;
          if (accept) begin
            ev_on <= note_on && velocity != 7'd0;
            ev_note <= note_num;
            ev_vel <= velocity;
            ev_wave <= wave_sel;
            idx <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            ram_we <= 1'b1;
            ram_addr <= idx;
            ram_wdata <= ev_on ? pack_param(ev_note, ev_vel, ev_wave, rom_phase) : '0;
            shadow_active[idx] <= ev_on;
            shadow_note[idx] <= ev_note;
            active_count <= ev_on ? active_count + 1'b1 : active_count - 1'b1;
            state <= WRITE;
          end else if (last && ev_on) begin
`ifdef VOICE_STEAL_EN
            ram_we <= 1'b1;
            ram_addr <= steal_ptr;
            ram_wdata <= pack_param(ev_note, ev_vel, ev_wave, rom_phase);
            shadow_note[steal_ptr] <= ev_note;
            steal_ptr <= steal_ptr + 1'b1;
            state <= WRITE;
`else
            voice_dropped <= 1'b1;
            note_ready <= 1'b1;
            state <= IDLE;
`endif
          end else if (last) begin
            note_ready <= 1'b1;
            state <= IDLE;
          end else idx <= idx + 1'b1;
        end
        WRITE: begin
          note_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: randomized scoreboard bench against a slot-array reference model
module tb_voice_allocator;
  logic clk = 1'b0, reset_n = 1'b0, note_valid = 1'b0, note_on = 1'b0;
  logic [6:0] note_num = '0, velocity = '0;
  logic [3:0] wave_sel = '0;
  logic note_ready, ram_we, voice_dropped;
  logic [7:0] ram_addr;
  logic [50:0] ram_wdata;
  logic [8:0] active_count;
  voice_allocator dut (.clk(clk), .reset_n(reset_n), .note_valid(note_valid), .note_ready(note_ready),
    .note_on(note_on), .note_num(note_num), .velocity(velocity), .wave_sel(wave_sel), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .active_count(active_count), .voice_dropped(voice_dropped));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int cyc; bit drop; logic [7:0] addr; logic [50:0] data; int count;} exp_t;
  exp_t q[$];
  exp_t e;
  int slots[256];
  int count = 0, sp = 0;
  int vectors = 0, miscompares = 0;
  function automatic logic [31:0] phase_ref(input int n);
    real f;
    f = 440.0 * 2.0 ** (real'(n - 69) / 12.0);
    return 32'($rtoi(f * 4294967296.0 / 48000.0 + 0.5));
  endfunction
  function automatic logic [50:0] word(input int n, input int v, input int w);
    return {1'b1, 7'(n), 7'(v), 4'(w), phase_ref(n)};
  endfunction
  // Every write or drop pulse must match the oldest outstanding expectation, cycle-exact
  always @(negedge clk) begin
    if (ram_we || voice_dropped) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output cyc=%0d we=%0b addr=%0d data=%h dropped=%0b, required no output",
                 cyc, ram_we, ram_addr, ram_wdata, voice_dropped);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.drop != voice_dropped || e.drop == ram_we || active_count != 9'(e.count) ||
            (!e.drop && (ram_addr != e.addr || ram_wdata != e.data))) begin
          miscompares++;
          $display("FAIL output cyc=%0d we=%0b drop=%0b addr=%0d data=%h count=%0d, required cyc=%0d drop=%0b addr=%0d data=%h count=%0d",
                   cyc, ram_we, voice_dropped, ram_addr, ram_wdata, active_count,
                   e.cyc, e.drop, e.addr, e.data, e.count);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask
  task automatic wait_ready(input int exp, input string nm);
    while (!note_ready && cyc < exp + 10) begin
      note_valid = 1'($urandom_range(0, 1));
      note_on = 1'($urandom_range(0, 1));
      note_num = 7'($urandom_range(0, 127));
      velocity = 7'($urandom_range(0, 127));
      wave_sel = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    note_valid = 1'b0;
    vectors++;
    if (!note_ready || cyc != exp) begin
      miscompares++;
      $display("FAIL %s: ready=%0b at cyc %0d, required ready at cyc %0d", nm, note_ready, cyc, exp);
    end
  endtask
  task automatic offer(input bit on, input int n, input int v, input int w, output int c);
    int t = 0;
    while (!note_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (!note_ready) begin
      miscompares++;
      $display("FAIL ready_timeout: note_ready=0 after %0d cycles, required 1", t);
      c = -1;
      return;
    end
    note_valid = 1'b1;
    note_on = on;
    note_num = 7'(n);
    velocity = 7'(v);
    wave_sel = 4'(w);
    c = cyc;
    @(negedge clk);
    note_valid = 1'b0;
  endtask
  task automatic send(input bit on, input int n, input int v, input int w);
    int c, h, rdy;
    offer(on, n, v, w, c);
    if (c < 0) return;
    h = -1;
    if (on && v != 0) begin
      for (int i = 0; i < 256; i++) if (slots[i] < 0) begin h = i; break; end
      if (h >= 0) begin
        q.push_back('{c + 2 + h, 1'b0, 8'(h), word(n, v, w), count + 1});
        slots[h] = n;
        count++;
        rdy = c + h + 3;
      end else begin
`ifdef VOICE_STEAL_EN
        q.push_back('{c + 257, 1'b0, 8'(sp), word(n, v, w), count});
        slots[sp] = n;
        sp = (sp + 1) % 256;
        rdy = c + 258;
`else
        q.push_back('{c + 257, 1'b1, 8'd0, 51'd0, count});
        rdy = c + 257;
`endif
      end
    end else begin
      for (int i = 0; i < 256; i++) if (slots[i] == n) begin h = i; break; end
      if (h >= 0) begin
        q.push_back('{c + 2 + h, 1'b0, 8'(h), 51'd0, count - 1});
        slots[h] = -1;
        count--;
        rdy = c + h + 3;
      end else rdy = c + 257;
    end
    wait_ready(rdy, "ready_after_event");
  endtask
  task automatic do_reset();
    int r;
    reset_n = 1'b0;
    note_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ram_we", 64'(ram_we), 64'd0);
    chk("reset_ram_addr", 64'(ram_addr), 64'd0);
    chk("reset_ram_wdata", 64'(ram_wdata), 64'd0);
    chk("reset_note_ready", 64'(note_ready), 64'd0);
    chk("reset_active_count", 64'(active_count), 64'd0);
    chk("reset_voice_dropped", 64'(voice_dropped), 64'd0);
    foreach (slots[i]) slots[i] = -1;
    count = 0;
    sp = 0;
    reset_n = 1'b1;
    r = cyc;
    for (int k = 0; k < 256; k++) q.push_back('{r + 1 + k, 1'b0, 8'(k), 51'd0, 0});
    wait_ready(r + 257, "ready_after_clear");
  endtask
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int c;
    @(negedge clk);
    do_reset();
    send(1'b1, 69, 100, 2);
    do_reset();
    send(1'b1, 60, 80, 1);
    send(1'b1, 64, 81, 3);
    send(1'b1, 67, 82, 4);
    send(1'b0, 64, 0, 0);
    send(1'b1, 72, 90, 5);
    do_reset();
    send(1'b1, 69, 50, 1);
    send(1'b1, 69, 0, 3);
    send(1'b0, 50, 0, 0);
    for (int i = 0; i < 256; i++)
      send(1'b1, $urandom_range(0, 127), $urandom_range(1, 127), $urandom_range(0, 15));
    send(1'b1, 100, 33, 7);
    send(1'b1, 101, 34, 8);
    for (int i = 0; i < 40; i++)
      send(1'($urandom_range(0, 1)), $urandom_range(0, 127),
           $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 127), $urandom_range(0, 15));
    do_reset();
    for (int i = 0; i < 60; i++) send(1'b1, 5, 10, 1);
    send(1'b1, 9, 20, 2);
    offer(1'b0, 9, 0, 0, c);
    repeat (29) @(negedge clk);
    do_reset();
    send(1'b1, 69, 100, 2);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
